// File: rtl/fc_bias_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fc_bias_sequencer: adds a per-neuron bias with signed saturation to an    |
// | FC-layer accumulator stream. Optional ReLU: FC_BIAS_RELU_EN.              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module fc_bias_sequencer #(
  parameter int NUM_NEURONS = 10,
  parameter int BIAS_WIDTH  = 32,
  parameter int ACC_WIDTH   = 32,
  parameter int DATA_WIDTH  = NUM_NEURONS * BIAS_WIDTH,
  parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] bias_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  acc_valid,
  output logic                  acc_ready,
  input  logic [ACC_WIDTH-1:0]  acc_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic                  out_last
);

  localparam logic [IDX_WIDTH-1:0] c_last_idx = IDX_WIDTH'(NUM_NEURONS - 1);
  localparam logic [ACC_WIDTH-1:0] c_sat_max  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] c_sat_min  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_WIDTH-1:0] r_bias;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic                  r_last_taken;
  logic                  r_out_valid;
  logic [ACC_WIDTH-1:0]  r_out_data;
  logic [IDX_WIDTH-1:0]  r_out_idx;
  logic                  r_out_last;

  logic                  w_busy;
  logic                  w_done;
  logic                  w_acc_ready;
  logic                  w_load;
  logic                  w_acc_xfer;
  logic                  w_out_xfer;

  logic [BIAS_WIDTH-1:0]        w_bias_arr [NUM_NEURONS];
  logic signed [BIAS_WIDTH-1:0] w_bias_s;
  logic signed [ACC_WIDTH:0]    w_sum;
  logic [ACC_WIDTH-1:0]         w_sat;
  logic [ACC_WIDTH-1:0]         w_result;

  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_bias_unpack
    assign w_bias_arr[gi] = r_bias[gi*BIAS_WIDTH +: BIAS_WIDTH];
  end

  // One guard bit is enough to detect overflow of a two-operand signed add.
  assign w_bias_s = w_bias_arr[r_idx];
  assign w_sum    = $signed({acc_data[ACC_WIDTH-1], acc_data}) + (ACC_WIDTH+1)'(w_bias_s);

  always_comb begin
    w_sat = w_sum[ACC_WIDTH-1:0];
    if (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]) begin
      w_sat = w_sum[ACC_WIDTH] ? c_sat_min : c_sat_max;
    end
  end

`ifdef FC_BIAS_RELU_EN
  assign w_result = w_sat[ACC_WIDTH-1] ? '0 : w_sat;
`else
  assign w_result = w_sat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_acc_ready  = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy      = 1'b1;
        w_acc_ready = !r_last_taken && (!r_out_valid || out_ready);
        if (r_out_valid && out_ready && r_out_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_acc_xfer = acc_valid && w_acc_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bias       <= '0;
      r_idx        <= '0;
      r_last_taken <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_idx    <= '0;
      r_out_last   <= 1'b0;
    end else begin
      if (w_load) begin
        r_bias       <= bias_data;
        r_idx        <= '0;
        r_last_taken <= 1'b0;
      end
      // A reload in the same cycle as an output transfer keeps out_valid high.
      if (w_acc_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_result;
        r_out_idx   <= r_idx;
        r_out_last  <= (r_idx == c_last_idx);
        if (r_idx == c_last_idx) begin
          r_last_taken <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign busy      = w_busy;
  assign done      = w_done;
  assign acc_ready = w_acc_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_fc_bias_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fc_bias_sequencer: randomized scoreboard bench for fc_bias_sequencer.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_fc_bias_sequencer;

  localparam int NN = 10;
  localparam int BW = 32;
  localparam int AW = 32;
  localparam int DW = NN * BW;
  localparam int IW = $clog2(NN);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] bias_data = '0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic          acc_valid = 1'b0;
  logic          acc_ready;
  logic [AW-1:0] acc_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] acc_vals [NN];

  always #5 clk = ~clk;

  fc_bias_sequencer #(
    .NUM_NEURONS(NN),
    .BIAS_WIDTH (BW),
    .ACC_WIDTH  (AW)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bias_data(bias_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .acc_valid(acc_valid),
    .acc_ready(acc_ready),
    .acc_data (acc_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer sum, clamp to the 32-bit signed range, optional ReLU.
  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
`ifdef FC_BIAS_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[31:0];
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(3))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // mode bits: 1 backpressure, 2 start+bias change mid-run, 4 reset abort, 8 throughput
  task automatic run_pass(input int pv, input int pr, input int mode);
    logic [31:0]   bcap [NN];
    logic [31:0]   expq [$];
    logic [31:0]   e;
    logic [AW-1:0] pd;
    logic [IW-1:0] pi;
    int  n_acc, n_out, cyc, bp;
    bit  bp_used, hold, fin, ax, ox;
    n_acc = 0; n_out = 0; cyc = 0; bp = 0;
    bp_used = 0; hold = 0; fin = 0;
    pd = '0; pi = '0;
    for (int i = 0; i < NN; i++) bcap[i] = bias_data[i*BW +: BW];
    start = 1'b1; acc_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    while (!fin && cyc < 3000) begin
      if ((mode & 1) != 0 && !bp_used && out_valid) begin
        bp = 5; bp_used = 1;
      end
      acc_valid = (n_acc < NN) && (bp > 0 || $urandom_range(99) < pv);
      acc_data  = acc_vals[n_acc < NN ? n_acc : 0];
      out_ready = (bp == 0) && ($urandom_range(99) < pr);
      start     = ((mode & 2) != 0 && cyc == 3);
      if ((mode & 2) != 0 && cyc == 3) bias_data = ~bias_data;
      #1;
      if (hold) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, pd);
        check_eq("hold_idx", out_idx, pi);
      end
      check_eq("done_low_in_run", done, 0);
      check_eq("busy_in_run", busy, 1);
      if (bp > 0) check_eq("bp_acc_ready", acc_ready, 0);
      if (n_acc == NN) check_eq("acc_ready_after_last", acc_ready, 0);
      ax = acc_valid && acc_ready;
      ox = out_valid && out_ready;
      if (ox) begin
        if (expq.size() == 0) begin
          check_eq("unexpected_out", expq.size(), 1);
        end else begin
          e = expq.pop_front();
          check_eq("out_data", out_data, e);
          check_eq("out_idx", out_idx, n_out);
          check_eq("out_last", out_last, (n_out == NN - 1));
        end
        n_out++;
        if (n_out == NN) begin
          fin = 1;
          if ((mode & 8) != 0) check_eq("throughput_cycles", cyc, NN);
        end
      end
      if (ax) begin
        expq.push_back(ref_result(acc_data, bcap[n_acc]));
        n_acc++;
      end
      hold = out_valid && !out_ready;
      pd = out_data; pi = out_idx;
      if (bp > 0) bp--;
      if ((mode & 4) != 0 && n_out == 4) begin
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_acc_ready", acc_ready, 0);
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_out_data", out_data, 0);
        check_eq("abort_out_idx", out_idx, 0);
        check_eq("abort_out_last", out_last, 0);
        acc_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          check_eq("abort_no_done", done, 0);
          check_eq("abort_idle", busy, 0);
        end
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("pass_completed", fin, 1);
    acc_valid = 1'b0; out_ready = 1'b0;
    start = 1'b1;  // must be ignored while done is high
    #1;
    check_eq("done_pulse", done, 1);
    check_eq("busy_in_done", busy, 1);
    check_eq("done_out_valid", out_valid, 0);
    check_eq("done_acc_ready", acc_ready, 0);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("done_cleared", done, 0);
    check_eq("busy_cleared", busy, 0);
    @(posedge clk); #1;
    check_eq("start_in_done_ignored", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_acc_ready", acc_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_idx", out_idx, 0);
    check_eq("rst_out_last", out_last, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_acc_ready", acc_ready, 0);

    for (int i = 0; i < NN; i++) begin
      bias_data[i*BW +: BW] = 32'(i * 16);
      acc_vals[i] = 32'h100;
    end
    run_pass(100, 100, 8);

    for (int i = 0; i < NN; i++) begin
      bias_data[i*BW +: BW] = $urandom;
      acc_vals[i] = $urandom;
    end
    bias_data[0*BW +: BW] = 32'h7FFF_FFFF; acc_vals[0] = 32'h0000_0002;
    bias_data[1*BW +: BW] = 32'h8000_0000; acc_vals[1] = 32'hFFFF_FFFF;
    bias_data[2*BW +: BW] = 32'h0000_0002; acc_vals[2] = 32'hFFFF_FFFB;
    run_pass(100, 100, 0);

    for (int i = 0; i < NN; i++) begin
      bias_data[i*BW +: BW] = rnd_val();
      acc_vals[i] = rnd_val();
    end
    run_pass(100, 100, 1);
    run_pass(80, 80, 2);
    run_pass(100, 100, 4);
    run_pass(100, 100, 8);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NN; i++) begin
        bias_data[i*BW +: BW] = rnd_val();
        acc_vals[i] = rnd_val();
      end
      run_pass(30 + int'($urandom_range(70)), 30 + int'($urandom_range(70)), 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
